// File: rtl/maze_seq.sv
// maze_seq: top-level run sequencer for the line-following maze runner.
// Takes host commands, enables the PID controller, detects line loss and
// hands intersections to the turn logic using a preloaded left/right pattern.
// When the pattern is used up and the line is lost, it buzzes and flags done.
module maze_seq #(
  parameter int LOST_SAMPLES = 8,
  parameter int BUZZ_CYCLES  = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic        line_present,
  input  logic        err_vld,
  input  logic        turn_done,
  output logic        go,
  output logic        turn_req,
  output logic        turn_dir,
  output logic        buzz,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_FOLLOW,
    ST_TURN,
    ST_BUZZ,
    ST_DONE
  } state_t;

  localparam logic [7:0]  LOST_LIMIT = 8'(LOST_SAMPLES);
  localparam logic [19:0] BUZZ_LAST  = 20'(BUZZ_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  pattern, pattern_nxt;
  logic [3:0]  turns_left, turns_nxt;
  logic [7:0]  lost_cnt, lost_nxt;
  logic [19:0] buzz_cnt, buzz_nxt;
  logic [7:0]  lost_inc;
  logic        cmd_accept;
  logic        cmd_taken;
  logic        idle_or_done;

  // A pending command is taken only when no acknowledge is already in flight,
  // so a host that holds cmd_rdy high is decoded at most every other cycle.
  assign cmd_accept   = cmd_rdy & ~clr_cmd_rdy;
  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
  assign lost_inc     = lost_cnt + 8'd1;

  // State and datapath registers, plus the one-cycle command acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pattern     <= 8'd0;
      turns_left  <= 4'd0;
      lost_cnt    <= 8'd0;
      buzz_cnt    <= 20'd0;
      clr_cmd_rdy <= 1'b0;
    end else begin
      state       <= state_nxt;
      pattern     <= pattern_nxt;
      turns_left  <= turns_nxt;
      lost_cnt    <= lost_nxt;
      buzz_cnt    <= buzz_nxt;
      clr_cmd_rdy <= cmd_accept;
    end
  end

  // Next-state logic: an effective command wins over the run transitions;
  // ignored or reserved commands leave the run logic undisturbed.
  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    turns_nxt   = turns_left;
    lost_nxt    = lost_cnt;
    buzz_nxt    = buzz_cnt;
    cmd_taken   = 1'b0;

    if (cmd_accept) begin
      case (cmd[15:14])
        2'b00: begin
          state_nxt = ST_IDLE;
          cmd_taken = 1'b1;
        end
        2'b01: begin
          if (idle_or_done) begin
            state_nxt = ST_WAIT_LINE;
            lost_nxt  = 8'd0;
            cmd_taken = 1'b1;
          end
        end
        2'b10: begin
          if (idle_or_done) begin
            pattern_nxt = cmd[7:0];
            turns_nxt   = (cmd[11:8] > 4'd8) ? 4'd8 : cmd[11:8];
            cmd_taken   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (!cmd_taken) begin
      case (state)
        ST_WAIT_LINE: begin
          if (line_present) begin
            state_nxt = ST_FOLLOW;
            lost_nxt  = 8'd0;
          end
        end
        ST_FOLLOW: begin
          if (err_vld) begin
            if (!line_present) begin
              lost_nxt = lost_inc;
              if (lost_inc == LOST_LIMIT) begin
                if (turns_left != 4'd0) begin
                  state_nxt = ST_TURN;
                end else begin
                  state_nxt = ST_BUZZ;
                  buzz_nxt  = 20'd0;
                end
              end
            end else begin
              lost_nxt = 8'd0;
            end
          end
        end
        ST_TURN: begin
          if (turn_done) begin
            pattern_nxt = {1'b0, pattern[7:1]};
            if (turns_left != 4'd0) begin
              turns_nxt = turns_left - 4'd1;
            end
            state_nxt = ST_WAIT_LINE;
          end
        end
        ST_BUZZ: begin
          if (buzz_cnt == BUZZ_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            buzz_nxt = buzz_cnt + 20'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded straight from the registered state.
  always_comb begin
    go       = 1'b0;
    turn_req = 1'b0;
    turn_dir = 1'b0;
    buzz     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_WAIT_LINE,
      ST_FOLLOW: go = 1'b1;
      ST_TURN: begin
        turn_req = 1'b1;
        turn_dir = pattern[0];
      end
      ST_BUZZ: buzz = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_seq.sv
// tb_maze_seq: scoreboard bench for the maze run sequencer. Stimulus tasks
// push the output events they expect; a negedge monitor turns DUT output
// activity into events and compares them against the queue in order.
module tb_maze_seq;

  localparam int LOST = 8;
  localparam int BUZZ_LEN = 20;

  localparam logic [3:0] EV_ACK  = 4'd1;
  localparam logic [3:0] EV_TURN = 4'd2;
  localparam logic [3:0] EV_BUZZ = 4'd3;
  localparam logic [3:0] EV_DONE = 4'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        line_present;
  logic        err_vld;
  logic        turn_done;
  logic        go;
  logic        turn_req;
  logic        turn_dir;
  logic        buzz;
  logic        done;

  int check_count = 0;
  int fail_count  = 0;
  logic [31:0] sb_q[$];

  maze_seq #(
    .LOST_SAMPLES(LOST),
    .BUZZ_CYCLES (BUZZ_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .line_present(line_present),
    .err_vld     (err_vld),
    .turn_done   (turn_done),
    .go          (go),
    .turn_req    (turn_req),
    .turn_dir    (turn_dir),
    .buzz        (buzz),
    .done        (done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string eventTag(input logic [31:0] ev);
    case (ev[31:28])
      EV_ACK:  return "ack_event";
      EV_TURN: return "turn_event";
      EV_BUZZ: return "buzz_event";
      EV_DONE: return "done_event";
      default: return "bad_event";
    endcase
  endfunction

  task automatic scoreboardCheck(input logic [31:0] ev);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      checkOutput("unexpected_event", ev, 32'hFFFF_FFFF);
    end else begin
      exp = sb_q.pop_front();
      checkOutput(eventTag(exp), ev, exp);
    end
  endtask

  // Monitor: converts acknowledges, turn requests, buzz bursts and done
  // into events and retires them against the scoreboard queue.
  logic prev_turn_req = 1'b0;
  logic prev_done     = 1'b0;
  int   buzz_len      = 0;
  always @(negedge clk) begin
    if (clr_cmd_rdy) scoreboardCheck({EV_ACK, 28'd0});
    if (turn_req && !prev_turn_req) scoreboardCheck({EV_TURN, 27'd0, turn_dir});
    if (buzz) begin
      buzz_len++;
    end else if (buzz_len != 0) begin
      scoreboardCheck({EV_BUZZ, 28'(buzz_len)});
      buzz_len = 0;
    end
    if (done && !prev_done) scoreboardCheck({EV_DONE, 28'd0});
    prev_turn_req = turn_req;
    prev_done     = done;
  end

  // Issue one host command and expect exactly one acknowledge for it.
  task automatic applyStimulus(input logic [15:0] c);
    sb_q.push_back({EV_ACK, 28'd0});
    @(negedge clk);
    cmd     = c;
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
  endtask

  task automatic applySamples(input int n, input logic lp);
    repeat (n) begin
      @(negedge clk);
      err_vld      = 1'b1;
      line_present = lp;
    end
    @(negedge clk);
    err_vld = 1'b0;
  endtask

  task automatic enterFollow();
    @(negedge clk);
    line_present = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulseTurnDone();
    @(negedge clk);
    turn_done = 1'b1;
    @(negedge clk);
    turn_done = 1'b0;
  endtask

  task automatic expectBuzzThenDone();
    sb_q.push_back({EV_BUZZ, 28'(BUZZ_LEN)});
    sb_q.push_back({EV_DONE, 28'd0});
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, done, 1'b1);
    checkOutput({tag, "_go"}, go, 1'b0);
    checkOutput({tag, "_buzz"}, buzz, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    cmd          = 16'h0000;
    cmd_rdy      = 1'b0;
    line_present = 1'b0;
    err_vld      = 1'b0;
    turn_done    = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_go", go, 1'b0);
    checkOutput("rst_turn_req", turn_req, 1'b0);
    checkOutput("rst_buzz", buzz, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_ack", clr_cmd_rdy, 1'b0);
    rst_n = 1'b1;

    // Pattern 0x05 with two turns: right then left, then the end of the maze.
    applyStimulus(16'h8205);
    checkOutput("load_no_go", go, 1'b0);
    applyStimulus(16'h4000);
    checkOutput("go_wait_line", go, 1'b1);
    enterFollow();
    checkOutput("go_follow", go, 1'b1);

    // A present sample in between restarts the loss count.
    applySamples(7, 1'b0);
    applySamples(1, 1'b1);
    applySamples(7, 1'b0);
    checkOutput("no_turn_after_7", turn_req, 1'b0);
    checkOutput("still_go_after_7", go, 1'b1);
    sb_q.push_back({EV_TURN, 28'd1});
    applySamples(1, 1'b0);
    checkOutput("turn1_req", turn_req, 1'b1);
    checkOutput("turn1_go_low", go, 1'b0);
    pulseTurnDone();
    checkOutput("after_turn1_go", go, 1'b1);
    checkOutput("after_turn1_req", turn_req, 1'b0);

    enterFollow();
    sb_q.push_back({EV_TURN, 28'd0});
    applySamples(LOST, 1'b0);
    checkOutput("turn2_req", turn_req, 1'b1);
    checkOutput("turn2_dir", turn_dir, 1'b0);
    pulseTurnDone();

    enterFollow();
    expectBuzzThenDone();
    applySamples(LOST, 1'b0);
    checkOutput("buzz_on", buzz, 1'b1);
    checkOutput("buzz_go_low", go, 1'b0);
    waitDone("run1_done");

    // STOP together with turn_done must leave the pattern unshifted.
    applyStimulus(16'h8201);
    applyStimulus(16'h4000);
    checkOutput("done_cleared_by_go", done, 1'b0);
    enterFollow();
    sb_q.push_back({EV_TURN, 28'd1});
    applySamples(LOST, 1'b0);
    sb_q.push_back({EV_ACK, 28'd0});
    @(negedge clk);
    cmd       = 16'h0000;
    cmd_rdy   = 1'b1;
    turn_done = 1'b1;
    @(negedge clk);
    cmd_rdy   = 1'b0;
    turn_done = 1'b0;
    checkOutput("stop_turn_req", turn_req, 1'b0);
    checkOutput("stop_go", go, 1'b0);
    applyStimulus(16'h4000);
    enterFollow();
    sb_q.push_back({EV_TURN, 28'd1});
    applySamples(LOST, 1'b0);
    checkOutput("unshifted_dir", turn_dir, 1'b1);
    pulseTurnDone();

    // GO in WAIT_LINE and LOAD in FOLLOW are acknowledged but ignored.
    applyStimulus(16'h4000);
    checkOutput("go_ignored_wait", go, 1'b1);
    enterFollow();
    applyStimulus(16'h88FF);
    sb_q.push_back({EV_ACK, 28'd0});
    sb_q.push_back({EV_ACK, 28'd0});
    @(negedge clk);
    cmd     = 16'hC000;
    cmd_rdy = 1'b1;
    repeat (3) @(negedge clk);
    cmd_rdy = 1'b0;
    sb_q.push_back({EV_TURN, 28'd0});
    applySamples(LOST, 1'b0);
    checkOutput("load_ignored_dir", turn_dir, 1'b0);
    pulseTurnDone();
    enterFollow();
    expectBuzzThenDone();
    applySamples(LOST, 1'b0);
    waitDone("run2_done");

    // GO from DONE with no turns left goes straight to the buzzer.
    applyStimulus(16'h4000);
    enterFollow();
    expectBuzzThenDone();
    applySamples(LOST, 1'b0);
    checkOutput("direct_buzz", buzz, 1'b1);
    waitDone("run3_done");
    applyStimulus(16'h0000);
    checkOutput("stop_from_done", done, 1'b0);

    // Reset mid-FOLLOW also clears the loaded turn count.
    applyStimulus(16'h8301);
    applyStimulus(16'h4000);
    enterFollow();
    applySamples(3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_go", go, 1'b0);
    checkOutput("midrst_turn_req", turn_req, 1'b0);
    checkOutput("midrst_buzz", buzz, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_ack", clr_cmd_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_idle", go, 1'b0);
    applyStimulus(16'h4000);
    enterFollow();
    expectBuzzThenDone();
    applySamples(LOST, 1'b0);
    checkOutput("midrst_turns_cleared", buzz, 1'b1);
    waitDone("run4_done");

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
